// File: rtl/writeback_unit_pkg.sv
// Shared types, widths and load-extract helper for the writeback slice.
// Imported by load_queue and writeback_unit.
package writeback_unit_pkg;

    localparam int XLEN         = 32;
    localparam int REG_SEL_BITS = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_SEL_BITS-1:0] rd;
        logic [2:0]              funct3;
        logic [1:0]              lsb;
    } ld_entry_t;

    // Pick the addressed byte/half out of an aligned word and extend it
    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      funct3,
        input logic [1:0]      lsb,
        input logic [XLEN-1:0] word
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        unique case (lsb)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lsb[1] ? word[31:16] : word[15:0];
        unique case (1'b1)
            (funct3 == F3_LB):  r = {{24{b[7]}}, b};
            (funct3 == F3_LH):  r = {{16{h[15]}}, h};
            (funct3 == F3_LBU): r = {24'b0, b};
            (funct3 == F3_LHU): r = {16'b0, h};
            default:            r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/writeback_unit_load_queue.sv
// In-order FIFO of outstanding loads with per-entry valid bits,
// so pending destinations can be matched against hazard queries.
module load_queue
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  ld_entry_t               push_entry,
    input  logic                    pop,
    output ld_entry_t               head,
    output logic                    empty,
    output logic                    full,
    output logic [AW:0]             count,
    input  logic [REG_SEL_BITS-1:0] query_rs1,
    input  logic [REG_SEL_BITS-1:0] query_rs2,
    output logic                    hit
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    ld_entry_t          mem [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // Entry storage; no reset needed, validity is tracked separately
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers, occupancy and valid bits; a push into the slot
    // being popped (full case) wins over the clear
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                valid[wr_ptr] <= 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Hazard match against every queued destination, x0 excluded
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                if (query_rs1 != '0 && mem[i].rd == query_rs1) begin
                    hit = 1'b1;
                end
                if (query_rs2 != '0 && mem[i].rd == query_rs2) begin
                    hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port driver: merges ALU results and in-order
// load responses into one registered write per cycle.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int CORE       = 0,
    parameter int LOAD_DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           alu_valid,
    input  logic [REG_SEL_BITS-1:0]        alu_rd,
    input  logic [XLEN-1:0]                alu_result,
    output logic                           alu_ready,
    input  logic                           ld_issue_valid,
    input  logic [REG_SEL_BITS-1:0]        ld_issue_rd,
    input  logic [2:0]                     ld_issue_funct3,
    input  logic [1:0]                     ld_issue_lsb,
    output logic                           ld_issue_ready,
    input  logic                           mem_resp_valid,
    input  logic [XLEN-1:0]                mem_resp_data,
    input  logic [REG_SEL_BITS-1:0]        query_rs1,
    input  logic [REG_SEL_BITS-1:0]        query_rs2,
    output logic                           pend_hit,
    output logic [$clog2(LOAD_DEPTH):0]    pending_count,
    output logic                           write,
    output logic [REG_SEL_BITS-1:0]        write_reg,
    output logic [XLEN-1:0]                write_data,
    output logic                           resp_error,
    input  logic                           report
);

    ld_entry_t       head;
    ld_entry_t       issue_entry;
    logic            q_empty;
    logic            q_full;
    logic            pop;
    logic            push;
    logic [XLEN-1:0] ld_data;

    // Tracing is not part of the synthesizable view; these only
    // keep the report input and core index on the interface
    logic            unused_report;
    logic [31:0]     unused_core;
    assign unused_report = report;
    assign unused_core   = CORE;

    assign pop            = mem_resp_valid & ~q_empty;
    assign alu_ready      = ~pop;
    assign ld_issue_ready = ~q_full | pop;
    assign push           = ld_issue_valid & ld_issue_ready;

    assign issue_entry.rd     = ld_issue_rd;
    assign issue_entry.funct3 = ld_issue_funct3;
    assign issue_entry.lsb    = ld_issue_lsb;

    assign ld_data = load_extract(head.funct3, head.lsb, mem_resp_data);

    load_queue #(
        .DEPTH(LOAD_DEPTH)
    ) u_load_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (issue_entry),
        .pop        (pop),
        .head       (head),
        .empty      (q_empty),
        .full       (q_full),
        .count      (pending_count),
        .query_rs1  (query_rs1),
        .query_rs2  (query_rs2),
        .hit        (pend_hit)
    );

    // Registered write port: load response first, then ALU; x0 is
    // never written and an idle cycle keeps the last select/data
    always_ff @(posedge clock) begin
        if (reset) begin
            write      <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            resp_error <= 1'b0;
        end else begin
            write <= 1'b0;
            if (pop) begin
                if (head.rd != '0) begin
                    write      <= 1'b1;
                    write_reg  <= head.rd;
                    write_data <= ld_data;
                end
            end else if (alu_valid) begin
                if (alu_rd != '0) begin
                    write      <= 1'b1;
                    write_reg  <= alu_rd;
                    write_data <= alu_result;
                end
            end
            if (mem_resp_valid && q_empty) begin
                resp_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed stimulus pushes
// expected writes, a negedge monitor pops and compares them.
module tb_writeback_unit;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_result = '0;
    logic        alu_ready;
    logic        ld_issue_valid = 1'b0;
    logic [4:0]  ld_issue_rd = '0;
    logic [2:0]  ld_issue_funct3 = '0;
    logic [1:0]  ld_issue_lsb = '0;
    logic        ld_issue_ready;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic [4:0]  query_rs1 = '0;
    logic [4:0]  query_rs2 = '0;
    logic        pend_hit;
    logic [2:0]  pending_count;
    logic        write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        resp_error;
    logic        report = 1'b0;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    writeback_unit #(
        .CORE(0),
        .LOAD_DEPTH(4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_result     (alu_result),
        .alu_ready      (alu_ready),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_funct3(ld_issue_funct3),
        .ld_issue_lsb   (ld_issue_lsb),
        .ld_issue_ready (ld_issue_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .query_rs1      (query_rs1),
        .query_rs2      (query_rs2),
        .pend_hit       (pend_hit),
        .pending_count  (pending_count),
        .write          (write),
        .write_reg      (write_reg),
        .write_data     (write_data),
        .resp_error     (resp_error),
        .report         (report)
    );

    always #5 clock = ~clock;

    // Monitor: every write the DUT presents must match the oldest expectation
    always @(negedge clock) begin
        if (!reset && write) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got reg=%0d data=%08h, required no write",
                         write_reg, write_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (write_reg !== e.rd || write_data !== e.data) begin
                    miscompares++;
                    $display("FAIL write: got reg=%0d data=%08h, required reg=%0d data=%08h",
                             write_reg, write_data, e.rd, e.data);
                end
            end
        end
    end

    // Hard stop in case the run never reaches its end
    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] lsb);
        ld_issue_valid  = 1'b1;
        ld_issue_rd     = rd;
        ld_issue_funct3 = f3;
        ld_issue_lsb    = lsb;
        tick();
        ld_issue_valid  = 1'b0;
    endtask

    task automatic resp(input logic [31:0] d);
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_write", 32'(write), 32'd0);
        check("rst_write_reg", 32'(write_reg), 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_count", 32'(pending_count), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_issue_ready", 32'(ld_issue_ready), 32'd1);
        reset = 1'b0;
        tick();

        // ALU only, then an idle cycle holds select/data
        alu_valid  = 1'b1;
        alu_rd     = 5'd5;
        alu_result = 32'h0000_1234;
        #1;
        check("alu_ready_alone", 32'(alu_ready), 32'd1);
        expect_write(5'd5, 32'h0000_1234);
        tick();
        alu_valid = 1'b0;
        tick();
        check("idle_write", 32'(write), 32'd0);
        check("idle_hold_reg", 32'(write_reg), 32'd5);
        check("idle_hold_data", write_data, 32'h0000_1234);

        // ALU to x0 is never written (monitor flags any write)
        alu_valid  = 1'b1;
        alu_rd     = 5'd0;
        alu_result = 32'hFFFF_FFFF;
        tick();
        alu_valid = 1'b0;
        tick();
        check("x0_alu_no_write", 32'(write), 32'd0);

        // LB sign extension and LBU on the same word
        issue(5'd7, LB, 2'd2);
        issue(5'd8, LBU, 2'd2);
        check("count_two", 32'(pending_count), 32'd2);
        expect_write(5'd7, 32'hFFFF_FF80);
        resp(32'h0080_0000);
        expect_write(5'd8, 32'h0000_0080);
        resp(32'h0080_0000);
        check("count_drained", 32'(pending_count), 32'd0);

        // ALU and load response collide: load goes first
        issue(5'd10, LW, 2'd0);
        alu_valid      = 1'b1;
        alu_rd         = 5'd3;
        alu_result     = 32'h0000_00AA;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        #1;
        check("alu_ready_conflict", 32'(alu_ready), 32'd0);
        expect_write(5'd10, 32'hDEAD_BEEF);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("alu_ready_after", 32'(alu_ready), 32'd1);
        expect_write(5'd3, 32'h0000_00AA);
        tick();
        alu_valid = 1'b0;

        // Fill the queue, then push and pop together
        issue(5'd11, LH, 2'd2);
        issue(5'd12, LHU, 2'd0);
        issue(5'd13, LB, 2'd1);
        issue(5'd14, LW, 2'd0);
        check("full_count", 32'(pending_count), 32'd4);
        check("full_not_ready", 32'(ld_issue_ready), 32'd0);
        ld_issue_valid  = 1'b1;
        ld_issue_rd     = 5'd15;
        ld_issue_funct3 = LBU;
        ld_issue_lsb    = 2'd3;
        mem_resp_valid  = 1'b1;
        mem_resp_data   = 32'hBEEF_1234;
        #1;
        check("full_pop_ready", 32'(ld_issue_ready), 32'd1);
        expect_write(5'd11, 32'hFFFF_BEEF);
        tick();
        ld_issue_valid = 1'b0;
        mem_resp_valid = 1'b0;
        check("full_swap_count", 32'(pending_count), 32'd4);
        expect_write(5'd12, 32'h0000_F00D);
        resp(32'h1234_F00D);
        expect_write(5'd13, 32'h0000_007F);
        resp(32'h0000_7F00);
        expect_write(5'd14, 32'hCAFE_BABE);
        resp(32'hCAFE_BABE);
        expect_write(5'd15, 32'h0000_009A);
        resp(32'h9A00_0000);
        check("swap_drained", 32'(pending_count), 32'd0);

        // Hazard tracking, including a load to x0
        issue(5'd9, LW, 2'd0);
        issue(5'd0, LW, 2'd0);
        query_rs2 = 5'd9;
        #1;
        check("hit_rs2", 32'(pend_hit), 32'd1);
        query_rs2 = 5'd0;
        query_rs1 = 5'd0;
        #1;
        check("hit_x0_never", 32'(pend_hit), 32'd0);
        query_rs1      = 5'd9;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0055;
        #1;
        check("hit_head_popping", 32'(pend_hit), 32'd1);
        expect_write(5'd9, 32'h0000_0055);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("hit_cleared", 32'(pend_hit), 32'd0);
        resp(32'h1111_1111);
        check("x0_load_popped", 32'(pending_count), 32'd0);
        check("x0_load_no_write", 32'(write), 32'd0);
        query_rs1 = 5'd0;

        // Response with an empty queue is sticky
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h7777_7777;
        #1;
        check("empty_resp_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        mem_resp_valid = 1'b0;
        check("empty_resp_no_write", 32'(write), 32'd0);
        check("resp_error_set", 32'(resp_error), 32'd1);
        tick();
        tick();
        check("resp_error_held", 32'(resp_error), 32'd1);

        // Reset with loads pending forgets them
        issue(5'd20, LW, 2'd0);
        issue(5'd21, LW, 2'd0);
        check("pre_reset_count", 32'(pending_count), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_count", 32'(pending_count), 32'd0);
        check("mid_reset_write", 32'(write), 32'd0);
        check("mid_reset_error", 32'(resp_error), 32'd0);
        resp(32'h2020_2020);
        check("post_reset_resp_error", 32'(resp_error), 32'd1);
        check("post_reset_no_write", 32'(write), 32'd0);

        tick();
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
